// File: rtl/buzzer_driver.sv
// buzzer_driver: plays one of seven notes in three octaves as a square wave.
// A single IDLE/TONE/GAP FSM latches the requested note, counts half-periods
// and inserts a silent articulation gap between consecutive distinct notes.
module buzzer_driver #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int GAP_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       speaker,
  output logic       playing,
  output logic [3:0] cur_note,
  output logic [1:0] cur_octave,
  output logic [7:0] note_count
);

  // Gap counter runs 0 .. GAP_CYCLES-1.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  // Middle-octave half-periods in clock cycles, one per note do..ti.
  localparam logic [19:0] H1 = 20'(CLK_HZ / (2 * 262));
  localparam logic [19:0] H2 = 20'(CLK_HZ / (2 * 294));
  localparam logic [19:0] H3 = 20'(CLK_HZ / (2 * 330));
  localparam logic [19:0] H4 = 20'(CLK_HZ / (2 * 349));
  localparam logic [19:0] H5 = 20'(CLK_HZ / (2 * 392));
  localparam logic [19:0] H6 = 20'(CLK_HZ / (2 * 440));
  localparam logic [19:0] H7 = 20'(CLK_HZ / (2 * 494));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [19:0] tone_cnt_reg, tone_cnt_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic        speaker_reg, speaker_next;
  logic [3:0]  note_reg, note_next;
  logic [1:0]  octave_reg, octave_next;
  logic [7:0]  count_reg, count_next;

  logic        note_valid;
  logic        request;
  logic [19:0] half;

  // Half-period for a latched note/octave; octave 11 behaves as high.
  function automatic logic [19:0] half_period(input logic [3:0] n, input logic [1:0] o);
    logic [19:0] h;
    case (n)
      4'd1:    h = H1;
      4'd2:    h = H2;
      4'd3:    h = H3;
      4'd4:    h = H4;
      4'd5:    h = H5;
      4'd6:    h = H6;
      4'd7:    h = H7;
      default: h = 20'd0;
    endcase
    case (o)
      2'b00:   half_period = h << 1;
      2'b01:   half_period = h;
      default: half_period = h >> 1;
    endcase
  endfunction

  assign note_valid = (note_in >= 4'd1) && (note_in <= 4'd7);
  assign request    = enable && note_valid;
  assign half       = half_period(note_reg, octave_reg);

  // State and datapath registers; reset acts immediately so speaker drops at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tone_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      speaker_reg  <= 1'b0;
      note_reg     <= 4'd0;
      octave_reg   <= 2'b01;
      count_reg    <= 8'd0;
    end else begin
      state_reg    <= state_next;
      tone_cnt_reg <= tone_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      speaker_reg  <= speaker_next;
      note_reg     <= note_next;
      octave_reg   <= octave_next;
      count_reg    <= count_next;
    end
  end

  // Next-state logic: disabling/invalid note wins over a note change in TONE.
  always_comb begin
    state_next    = state_reg;
    tone_cnt_next = tone_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    speaker_next  = speaker_reg;
    note_next     = note_reg;
    octave_next   = octave_reg;
    count_next    = count_reg;
    case (state_reg)
      IDLE: begin
        speaker_next = 1'b0;
        if (request) begin
          note_next     = note_in;
          octave_next   = octave_in;
          tone_cnt_next = '0;
          count_next    = count_reg + 8'd1;
          state_next    = TONE;
        end
      end
      TONE: begin
        if (!request) begin
          speaker_next = 1'b0;
          state_next   = IDLE;
        end else if ((note_in != note_reg) || (octave_in != octave_reg)) begin
          speaker_next = 1'b0;
          gap_cnt_next = '0;
          state_next   = GAP;
        end else if (tone_cnt_reg == half - 20'd1) begin
          tone_cnt_next = '0;
          speaker_next  = ~speaker_reg;
        end else begin
          tone_cnt_next = tone_cnt_reg + 20'd1;
        end
      end
      GAP: begin
        speaker_next = 1'b0;
        if (gap_cnt_reg == GAP_LAST) begin
          if (request) begin
            note_next     = note_in;
            octave_next   = octave_in;
            tone_cnt_next = '0;
            count_next    = count_reg + 8'd1;
            state_next    = TONE;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + GW'(1);
        end
      end
      default: begin
        speaker_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  assign speaker    = speaker_reg;
  assign playing    = (state_reg == TONE);
  assign cur_note   = note_reg;
  assign cur_octave = octave_reg;
  assign note_count = count_reg;

endmodule

// File: tb/tb_buzzer_driver.sv
// tb_buzzer_driver: random note sequences against a frequency-table model.
// Stimulus pushes the tone it expects to hear; a monitor pops one record
// every time the DUT starts playing and measures gap, phase and period.
module tb_buzzer_driver;

  localparam int CLK_HZ = 200_000;
  localparam int GAP    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic       speaker;
  logic       playing;
  logic [3:0] cur_note;
  logic [1:0] cur_octave;
  logic [7:0] note_count;

  always #5 clk = ~clk;

  buzzer_driver #(.CLK_HZ(CLK_HZ), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .note_in(note_in),
    .octave_in(octave_in), .speaker(speaker), .playing(playing),
    .cur_note(cur_note), .cur_octave(cur_octave), .note_count(note_count)
  );

  typedef struct {
    int note;
    int oct;
    int count;
    int h;
    int gap;      // expected silent negedge samples before the tone, -1 = don't care
    bit measure;  // measure first rise and period
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int fails  = 0;
  int model_count = 0;
  int cur_n = 0;
  int cur_o = 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference half-period straight from the note frequency table.
  function automatic int model_h(input int n, input int o);
    int f;
    int base;
    case (n)
      1: f = 262; 2: f = 294; 3: f = 330; 4: f = 349;
      5: f = 392; 6: f = 440; default: f = 494;
    endcase
    base = CLK_HZ / (2 * f);
    if (o == 0) return base * 2;
    if (o == 1) return base;
    return base / 2;
  endfunction

  function automatic int eff_oct(input int o);
    return (o == 3) ? 2 : o;
  endfunction

  task automatic push_tone(input int n, input int o, input int gap, input bit measure);
    exp_t e;
    model_count = (model_count + 1) % 256;
    e.note = n; e.oct = o; e.count = model_count; e.h = model_h(n, o);
    e.gap = gap; e.measure = measure;
    exp_q.push_back(e);
    cur_n = n;
    cur_o = o;
  endtask

  task automatic drive(input int n, input int o);
    enable    = 1'b1;
    note_in   = 4'(n);
    octave_in = 2'(o);
  endtask

  task automatic hold(input int n, input int o);
    repeat (3 * model_h(n, o) + 20) @(negedge clk);
  endtask

  // Start a tone while the FSM is idle.
  task automatic start_from_idle(input int n, input int o, input int gap);
    drive(n, o);
    push_tone(n, o, gap, 1'b1);
    hold(n, o);
  endtask

  // Switch directly to a different note; inputs wiggle during the gap.
  task automatic change_to(input int n, input int o);
    drive(n, o);
    push_tone(n, o, GAP, 1'b1);
    repeat (3) @(negedge clk);
    note_in = 4'($urandom_range(0, 15));
    enable  = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk);
    drive(n, o);
    repeat (GAP - 6) @(negedge clk);
    hold(n, o);
  endtask

  // Rest for r cycles, then request the next note from IDLE.
  task automatic rest_then(input int n, input int o, input int r);
    note_in = 4'd0;
    repeat (r) @(negedge clk);
    drive(n, o);
    push_tone(n, o, r, 1'b1);
    hold(n, o);
  endtask

  task automatic next_note(input int n, input int o);
    if (((n != cur_n) || (eff_oct(o) != eff_oct(cur_o))) && ($urandom_range(0, 2) != 0))
      change_to(n, o);
    else
      rest_then(n, o, $urandom_range(1, 20));
  endtask

  // Monitor: one record per tone start.
  bit   mon_prev = 1'b0;
  bit   mon_silent_bad = 1'b0;
  int   mon_low_run = 0;
  exp_t mon_e;
  int   mon_n;
  int   mon_m;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (playing && !mon_prev) begin
        if (exp_q.size() == 0) begin
          check("tone_expected", 0, 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("cur_note", int'(cur_note), mon_e.note);
          check("cur_octave", int'(cur_octave), mon_e.oct);
          check("note_count", int'(note_count), mon_e.count);
          if (mon_e.gap >= 0) check("silent_cycles", mon_low_run, mon_e.gap);
          check("speaker_quiet_when_silent", int'(mon_silent_bad), 0);
          mon_silent_bad = 1'b0;
          if (mon_e.measure) begin
            mon_n = 0;
            while (!speaker && mon_n < 4 * mon_e.h + 50) begin
              @(negedge clk);
              mon_n++;
            end
            check("first_rise", mon_n, mon_e.h);
            mon_m = 0;
            while (speaker && mon_m < 4 * mon_e.h + 50) begin
              @(negedge clk);
              mon_m++;
            end
            while (!speaker && mon_m < 4 * mon_e.h + 50) begin
              @(negedge clk);
              mon_m++;
            end
            check("period", mon_m, 2 * mon_e.h);
          end
          $display("tone note=%0d oct=%0d count=%0d h=%0d", mon_e.note, mon_e.oct, mon_e.count, mon_e.h);
        end
        mon_low_run = 0;
      end else if (!playing) begin
        mon_low_run++;
        if (speaker) mon_silent_bad = 1'b1;
      end
      mon_prev = playing;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int o;
    reset = 1'b1; enable = 1'b0; note_in = 4'd0; octave_in = 2'b00;
    #2;
    check("reset_speaker", int'(speaker), 0);
    check("reset_playing", int'(playing), 0);
    check("reset_cur_note", int'(cur_note), 0);
    check("reset_cur_octave", int'(cur_octave), 1);
    check("reset_note_count", int'(note_count), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    $display("reset released");

    // Out-of-range note code is a rest even with enable high.
    enable = 1'b1; note_in = 4'd9; octave_in = 2'b01;
    repeat (12) @(negedge clk);
    check("invalid_note_playing", int'(playing), 0);
    check("invalid_note_count", int'(note_count), 0);
    $display("invalid note held idle");

    start_from_idle(6, 1, -1);
    change_to(5, 1);
    next_note(1, 0);
    next_note(1, 2);
    next_note(1, 3);
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 7);
      o = $urandom_range(0, 3);
      next_note(n, o);
    end

    // Enable drop together with a note change goes straight to IDLE.
    enable = 1'b0;
    n = (cur_n % 7) + 1;
    note_in = 4'(n);
    @(negedge clk);
    check("drop_speaker", int'(speaker), 0);
    check("drop_playing", int'(playing), 0);
    $display("enable drop with note change");
    drive(n, cur_o);
    push_tone(n, cur_o, 1, 1'b1);
    hold(n, cur_o);

    // Asynchronous reset while the speaker is high.
    mon_n = 0;
    while (!speaker && mon_n < 2000) begin
      @(negedge clk);
      mon_n++;
    end
    check("speaker_high_before_reset", int'(speaker), 1);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("async_reset_speaker", int'(speaker), 0);
    check("async_reset_playing", int'(playing), 0);
    check("async_reset_count", int'(note_count), 0);
    $display("async reset mid-tone");
    @(negedge clk);
    reset = 1'b0;
    model_count = 0;
    @(negedge clk);

    // 256 rest/note alternations wrap the counter.
    for (int i = 0; i < 256; i++) begin
      n = $urandom_range(1, 7);
      o = $urandom_range(0, 3);
      drive(n, o);
      push_tone(n, o, (i == 0) ? -1 : 1, 1'b0);
      @(negedge clk);
      note_in = 4'd0;
      @(negedge clk);
    end
    @(negedge clk);
    check("wrap_note_count", int'(note_count), 0);
    $display("wrap after 256 tones");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/buzzer_driver.md
BUZZER_DRIVER -- requirements
Module: buzzer_driver

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter GAP_CYCLES, default 1_000_000, silent articulation gap inserted between consecutive distinct notes.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-005 enable  in  1  high = playback allowed; low = silence.
REQ-006 note_in  in  4  note code: 0 = rest, 1..7 = do..ti (C..B), 8..15 = treated as rest.
REQ-007 octave_in  in  2  00 low, 01 middle, 10 high, 11 treated as high.
REQ-008 speaker  out  1  square-wave drive to the buzzer.
REQ-009 playing  out  1  high while in state TONE.
REQ-010 cur_note  out  4  latched note code being sounded.
REQ-011 cur_octave  out  2  latched octave being sounded.
REQ-012 note_count  out  8  number of TONE entries, wraps 255->0.

Function
REQ-013 The block SHALL implement states IDLE, TONE, GAP in a single FSM.
REQ-014 A note SHALL be valid iff note_in is in 1..7; a request SHALL be active iff enable=1 and the note is valid.
REQ-015 Middle-octave half-period H SHALL be floor(CLK_HZ/(2*f)) for f = 262, 294, 330, 349, 392, 440, 494 Hz (notes 1..7); at the defaults H = 190839, 170068, 151515, 143266, 127551, 113636, 101214.
REQ-016 Low octave SHALL use H<<1, high octave H>>1 (truncating), all held in a 20-bit counter.
REQ-017 IDLE: speaker=0, playing=0; on an active request, latch note_in/octave_in into cur_note/cur_octave, clear the half-period counter, set speaker=0, increment note_count, and enter TONE on the next edge.
REQ-018 TONE: the counter SHALL increment every cycle; when it equals H-1 it SHALL clear and toggle speaker, giving a first rising edge H cycles after TONE entry and an exact period of 2H cycles.
REQ-019 TONE, enable=0 or invalid note: the FSM SHALL go to IDLE, with speaker=0 on the next cycle; this takes priority over every other transition.
REQ-020 TONE, active request whose (note, octave) differs from (cur_note, cur_octave): the FSM SHALL go to GAP, clearing speaker and the gap counter.
REQ-021 GAP: speaker=0, playing=0; after exactly GAP_CYCLES cycles in GAP, the FSM SHALL re-sample the inputs.
  - Active request: latch the inputs, increment note_count, enter TONE as in REQ-017.
  - Otherwise: enter IDLE.
  - Input changes during GAP SHALL have no effect until the gap ends.
REQ-022 An unchanged (note, octave) in TONE SHALL NOT restart the counter or alter phase.
REQ-023 cur_note/cur_octave SHALL retain their last latched values in IDLE and GAP.

Reset
REQ-024 On reset the outputs SHALL take these values:
  - state IDLE
  - speaker 0, playing 0
  - cur_note 0000, cur_octave 01
  - note_count 0
  - all counters 0
REQ-025 Reset asserted during TONE or GAP SHALL drive speaker to 0 without waiting for a clock edge, and SHALL abandon the current note.

Verification
REQ-026 Defaults: reset, then enable=1, note_in=6, octave_in=01 -> playing=1 after one edge; speaker rises 113636 cycles after TONE entry; period 227272 cycles; note_count=1.
REQ-027 Octave scaling: note_in=1 with octave_in=00 -> half-period 381678; with octave 10 -> 95419; with octave 11 -> 95419.
REQ-028 GAP_CYCLES=8: change note 6->5 in TONE -> speaker=0 and playing=0 for 8 cycles; then TONE with half-period 127551, cur_note=5, note_count=2.
REQ-029 Simultaneous events: in TONE, drop enable in the same cycle as the note changes -> IDLE (not GAP) with speaker=0 next cycle; note_in=9 with enable=1 -> remains IDLE.
REQ-030 Async reset mid-tone: assert reset between clk edges while speaker=1 -> speaker=0 and playing=0 before the next edge; note_count=0.
REQ-031 Wrap: 256 rest/note alternations -> note_count returns to 0.
